// File: rtl/hostctrl_pkg.sv
// Shared types and helpers for the host-control program loader.
package hostctrl_pkg;

  // Writer FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE,
    ERROR
  } wr_state_e;

  // One buffered bus word and its byte-lane enables.
  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
  } fifo_entry_t;

  // Number of host beats packed into one 32-bit word (LANES).
  function automatic int unsigned lanes_f(input int unsigned host_w);
    return 32 / host_w;
  endfunction

  // Width of the lane index; a single-lane packer still keeps one bit.
  function automatic int unsigned lane_w_f(input int unsigned host_w);
    return (host_w == 32) ? 1 : $clog2(32 / host_w);
  endfunction

  // Expand byte enables into a 32-bit data mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/hostctrl_loader_if.sv
// Wishbone classic write-master bus between the loader and the SoC RAM.
interface hostctrl_loader_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    input  wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    output wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/hostctrl_fifo.sv
// Synchronous word FIFO holding packed {dat, sel} entries for the writer.
module hostctrl_fifo
  import hostctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t din_i,
  input  logic        pop_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pointer/count update; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW + 1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW + 1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/hostctrl_loader.sv
// Boot loader: packs host beats into 32-bit words, buffers them and writes
// them to RAM over Wishbone, holding the CPU in reset until the image lands.
module hostctrl_loader
  import hostctrl_pkg::*;
#(
  parameter int unsigned HOST_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [HOST_W-1:0] host_data_i,
  input  logic              host_valid_i,
  input  logic              host_done_i,
  output logic              host_ack_o,
  hostctrl_loader_if.master wb,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              error_o,
  output logic [29:0]       word_cnt_o,
  output logic [31:0]       sum_o
);

  localparam int unsigned       LANES     = lanes_f(HOST_W);
  localparam int unsigned       LANE_W    = lane_w_f(HOST_W);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [3:0]        LANE_SEL  = 4'((1 << (HOST_W / 8)) - 1);
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       pdat_q, pdat_d;
  logic [3:0]        psel_q, psel_d;
  logic              done_q, done_d;
  logic              ack_q;
  logic [5:0]        shift;
  logic [31:0]       lane_dat;
  logic [3:0]        lane_sel;
  logic              consume, flush, push, pop;
  fifo_entry_t       push_ent, head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  wr_state_e         state_q, state_d;
  logic [31:0]       adr_q, adr_d, dat_q, dat_d, sum_q, sum_d;
  logic [3:0]        sel_q, sel_d;
  logic [29:0]       cnt_q, cnt_d;

  // Reset synchronizer: asserts immediately, releases two edges after the pin.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= '0;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Position of the current beat inside the word and its byte enables.
  always_comb begin
    if (BIG_ENDIAN) shift = 6'(32 - HOST_W * (32'(lane_q) + 1));
    else            shift = 6'(HOST_W * 32'(lane_q));
    lane_dat = 32'(host_data_i) << shift;
    lane_sel = LANE_SEL << shift[5:3];
  end

  // Packer: consume/flush decisions and next lane/word/done state.
  // Flush waits while a beat is still offered so a beat arriving together
  // with done is packed instead of being cut off by a premature flush.
  always_comb begin
    consume = host_valid_i && !ack_q && !fifo_full && (state_q != ERROR) && !done_q;
    flush   = host_done_i && !host_valid_i && !done_q &&
              ((lane_q == '0) || !fifo_full);
    push    = (consume && (lane_q == LAST_LANE)) || (flush && (lane_q != '0));
    push_ent.dat = consume ? (pdat_q | lane_dat) : pdat_q;
    push_ent.sel = consume ? (psel_q | lane_sel) : psel_q;
    lane_d = lane_q;
    pdat_d = pdat_q;
    psel_d = psel_q;
    done_d = done_q;
    if (consume) begin
      if (lane_q == LAST_LANE) begin
        lane_d = '0;
        pdat_d = '0;
        psel_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        pdat_d = pdat_q | lane_dat;
        psel_d = psel_q | lane_sel;
      end
    end else if (flush) begin
      lane_d = '0;
      pdat_d = '0;
      psel_d = '0;
      done_d = 1'b1;
    end
  end

  // Packer registers and the registered host acknowledge.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pdat_q <= '0;
      psel_q <= '0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pdat_q <= pdat_d;
      psel_q <= psel_d;
      done_q <= done_d;
      ack_q  <= consume;
    end
  end

  hostctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (rst_n),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Writer FSM next state, bus word capture, counters.
  // Completing the final word goes straight to DONE so load_done follows
  // the last ack by one cycle instead of taking an extra IDLE pass.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WRITE;
          adr_d   = BASE_ADR + {cnt_q, 2'b00};
          dat_d   = head.dat;
          sel_d   = head.sel;
        end else if (done_q && (lane_q == '0)) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        if (wb.wb_err_i) begin
          state_d = ERROR;
        end else if (wb.wb_ack_i) begin
          pop   = 1'b1;
          cnt_d = cnt_q + 30'd1;
          sum_d = sum_q + (dat_q & sel_mask(sel_q));
          if (done_q && (lane_q == '0) && (fifo_cnt == CNT_W'(1))) state_d = DONE;
          else                                                      state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Writer registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign wb.wb_cyc_o = (state_q == WRITE);
  assign wb.wb_stb_o = (state_q == WRITE);
  assign wb.wb_we_o  = (state_q == WRITE);
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_cti_o = 3'b000;
  assign wb.wb_bte_o = 2'b00;

  assign host_ack_o  = ack_q;
  assign cpu_rst_o   = (state_q != DONE);
  assign load_done_o = (state_q == DONE);
  assign error_o     = (state_q == ERROR);
  assign word_cnt_o  = cnt_q;
  assign sum_o       = sum_q;

endmodule

// File: tb/tb_hostctrl_loader.sv
// Directed bench for hostctrl_loader: two 8-bit loaders (big/little endian)
// share one host stream; a 16-bit loader covers FIFO back-pressure.
module tb_hostctrl_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;

  logic [7:0]  h8_data;
  logic        h8_valid, h8_done;
  logic [15:0] h16_data;
  logic        h16_valid, h16_done;

  logic        a_ack, a_cpu, a_ld, a_err;
  logic [29:0] a_wc;
  logic [31:0] a_sum;
  logic        b_ack, b_cpu, b_ld, b_err;
  logic [29:0] b_wc;
  logic [31:0] b_sum;
  logic        c_ack, c_cpu, c_ld, c_err;
  logic [29:0] c_wc;
  logic [31:0] c_sum;

  hostctrl_loader_if bus [3] ();

  hostctrl_loader #(.HOST_W(8), .FIFO_DEPTH(4), .BASE_ADR(32'h100), .BIG_ENDIAN(1'b1)) dut_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .host_data_i(h8_data), .host_valid_i(h8_valid),
    .host_done_i(h8_done), .host_ack_o(a_ack), .wb(bus[0]), .cpu_rst_o(a_cpu),
    .load_done_o(a_ld), .error_o(a_err), .word_cnt_o(a_wc), .sum_o(a_sum));

  hostctrl_loader #(.HOST_W(8), .FIFO_DEPTH(4), .BASE_ADR(32'h100), .BIG_ENDIAN(1'b0)) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .host_data_i(h8_data), .host_valid_i(h8_valid),
    .host_done_i(h8_done), .host_ack_o(b_ack), .wb(bus[1]), .cpu_rst_o(b_cpu),
    .load_done_o(b_ld), .error_o(b_err), .word_cnt_o(b_wc), .sum_o(b_sum));

  hostctrl_loader #(.HOST_W(16), .FIFO_DEPTH(4), .BASE_ADR(32'h200), .BIG_ENDIAN(1'b0)) dut_c (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .host_data_i(h16_data), .host_valid_i(h16_valid),
    .host_done_i(h16_done), .host_ack_o(c_ack), .wb(bus[2]), .cpu_rst_o(c_cpu),
    .load_done_o(c_ld), .error_o(c_err), .word_cnt_o(c_wc), .sum_o(c_sum));

  // RAM slave per loader: optional stall, optional error on write number err_at.
  for (genvar k = 0; k < 3; k++) begin : g_slv
    int          stall  = 0;
    int          err_at = -1;
    int          wt     = 0;
    int          nw     = 0;
    logic [31:0] adr_log [16];
    logic [31:0] dat_log [16];
    logic [3:0]  sel_log [16];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bus[k].wb_ack_i <= 1'b0;
        bus[k].wb_err_i <= 1'b0;
        wt <= 0;
        nw <= 0;
      end else begin
        bus[k].wb_ack_i <= 1'b0;
        bus[k].wb_err_i <= 1'b0;
        if (bus[k].wb_cyc_o && bus[k].wb_stb_o && !bus[k].wb_ack_i && !bus[k].wb_err_i) begin
          if (wt < stall) begin
            wt <= wt + 1;
          end else begin
            wt <= 0;
            if (nw == err_at) begin
              bus[k].wb_err_i <= 1'b1;
            end else begin
              bus[k].wb_ack_i <= 1'b1;
              if (nw < 16) begin
                adr_log[nw[3:0]] <= bus[k].wb_adr_o;
                dat_log[nw[3:0]] <= bus[k].wb_dat_o;
                sel_log[nw[3:0]] <= bus[k].wb_sel_o;
              end
              nw <= nw + 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    h8_valid  = 1'b0;
    h8_done   = 1'b0;
    h16_valid = 1'b0;
    h16_done  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Offer one byte to loaders A/B and return at the negedge its ack is seen.
  task automatic send8(input logic [7:0] b);
    int t;
    t = 0;
    h8_data  = b;
    h8_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!a_ack && t < 200);
    h8_valid = 1'b0;
    if (!a_ack) check("ack8_timeout", {31'd0, a_ack}, 32'd1);
  endtask

  task automatic wait_ld_a();
    for (int t = 0; t < 400 && !a_ld; t++) @(negedge clk);
  endtask

  logic [7:0]  img1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0]  img2 [3] = '{8'hAA, 8'hBB, 8'hCC};
  logic [7:0]  img3 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [15:0] lo, hi;
  logic [31:0] exp_w, exp_sum;
  int          t, gmax, acks;

  initial begin
    h8_data = '0; h16_data = '0;
    h8_valid = 1'b0; h8_done = 1'b0; h16_valid = 1'b0; h16_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_ack",  {31'd0, a_ack}, 32'd0);
    check("rst_cyc",  {31'd0, bus[0].wb_cyc_o}, 32'd0);
    check("rst_adr",  bus[0].wb_adr_o, 32'd0);
    check("rst_sel",  {28'd0, bus[0].wb_sel_o}, 32'd0);
    check("rst_cpu",  {31'd0, a_cpu}, 32'd1);
    check("rst_ld",   {31'd0, a_ld}, 32'd0);
    check("rst_wc",   {2'd0, a_wc}, 32'd0);
    check("rst_sum",  a_sum, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two full words, both endiannesses.
    foreach (img1[i]) send8(img1[i]);
    h8_done = 1'b1;
    wait_ld_a();
    check("t1_ld",    {31'd0, a_ld}, 32'd1);
    check("t1_cpu",   {31'd0, a_cpu}, 32'd0);
    check("t1_nw",    g_slv[0].nw, 32'd2);
    check("t1_adr0",  g_slv[0].adr_log[0], 32'h100);
    check("t1_dat0",  g_slv[0].dat_log[0], 32'h11223344);
    check("t1_sel0",  {28'd0, g_slv[0].sel_log[0]}, 32'hF);
    check("t1_adr1",  g_slv[0].adr_log[1], 32'h104);
    check("t1_dat1",  g_slv[0].dat_log[1], 32'h55667788);
    check("t1_wc",    {2'd0, a_wc}, 32'd2);
    check("t1_sum",   a_sum, 32'h6688AACC);
    check("t1_b_dat0", g_slv[1].dat_log[0], 32'h44332211);
    check("t1_b_dat1", g_slv[1].dat_log[1], 32'h88776655);
    check("t1_b_sum", b_sum, 32'hCCAA8866);

    // Trailing partial word.
    do_reset();
    foreach (img2[i]) send8(img2[i]);
    h8_done = 1'b1;
    wait_ld_a();
    check("t2_ld",    {31'd0, a_ld}, 32'd1);
    check("t2_nw",    g_slv[0].nw, 32'd1);
    check("t2_a_dat", g_slv[0].dat_log[0], 32'hAABBCC00);
    check("t2_a_sel", {28'd0, g_slv[0].sel_log[0]}, 32'hE);
    check("t2_b_dat", g_slv[1].dat_log[0], 32'h00CCBBAA);
    check("t2_b_sel", {28'd0, g_slv[1].sel_log[0]}, 32'h7);
    check("t2_b_sum", b_sum, 32'h00CCBBAA);
    check("t2_b_wc",  {2'd0, b_wc}, 32'd1);

    // Last byte offered together with done: no extra flush write.
    do_reset();
    send8(8'h01); send8(8'h02); send8(8'h03);
    h8_done = 1'b1;
    send8(8'h04);
    wait_ld_a();
    repeat (5) @(negedge clk);
    check("t3_ld",  {31'd0, a_ld}, 32'd1);
    check("t3_nw",  g_slv[0].nw, 32'd1);
    check("t3_dat", g_slv[0].dat_log[0], 32'h01020304);
    check("t3_sel", {28'd0, g_slv[0].sel_log[0]}, 32'hF);
    check("t3_wc",  {2'd0, a_wc}, 32'd1);

    // Bus error on the second write.
    do_reset();
    g_slv[0].err_at = 1;
    g_slv[1].err_at = 1;
    foreach (img1[i]) send8(img1[i]);
    for (t = 0; t < 200 && !a_err; t++) @(negedge clk);
    check("t4_err", {31'd0, a_err}, 32'd1);
    check("t4_cpu", {31'd0, a_cpu}, 32'd1);
    check("t4_wc",  {2'd0, a_wc}, 32'd1);
    check("t4_ld",  {31'd0, a_ld}, 32'd0);
    check("t4_adr0", g_slv[0].adr_log[0], 32'h100);
    acks = 0;
    h8_data  = 8'h99;
    h8_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    h8_valid = 1'b0;
    check("t4_noack", acks, 32'd0);
    check("t4_cyc",   {31'd0, bus[0].wb_cyc_o}, 32'd0);
    g_slv[0].err_at = -1;
    g_slv[1].err_at = -1;

    // 16-bit stream against a slow slave: back-pressure, order, no loss.
    do_reset();
    g_slv[2].stall = 20;
    gmax = 0;
    h16_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      h16_data = 16'h1000 + 16'(i);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!c_ack && t < 400);
      if (!c_ack) check("ack16_timeout", {31'd0, c_ack}, 32'd1);
      if (t > gmax) gmax = t;
    end
    h16_valid = 1'b0;
    h16_done  = 1'b1;
    for (t = 0; t < 1000 && !c_ld; t++) @(negedge clk);
    check("t5_hold", (gmax > 20) ? 32'd1 : 32'd0, 32'd1);
    check("t5_ld",   {31'd0, c_ld}, 32'd1);
    check("t5_nw",   g_slv[2].nw, 32'd8);
    exp_sum = '0;
    for (int i = 0; i < 8; i++) begin
      lo = 16'h1000 + 16'(2 * i);
      hi = 16'h1000 + 16'(2 * i + 1);
      exp_w = {hi, lo};
      exp_sum = exp_sum + exp_w;
      check($sformatf("t5_dat%0d", i), g_slv[2].dat_log[i], exp_w);
      check($sformatf("t5_adr%0d", i), g_slv[2].adr_log[i], 32'h200 + 32'(4 * i));
    end
    check("t5_wc",  {2'd0, c_wc}, 32'd8);
    check("t5_sum", c_sum, exp_sum);
    g_slv[2].stall = 0;

    // Reset while a write is outstanding.
    do_reset();
    g_slv[0].stall = 50;
    g_slv[1].stall = 50;
    foreach (img3[i]) send8(img3[i]);
    for (t = 0; t < 20 && !bus[0].wb_cyc_o; t++) @(negedge clk);
    check("t6_cyc_before", {31'd0, bus[0].wb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_cyc", {31'd0, bus[0].wb_cyc_o}, 32'd0);
    check("t6_stb", {31'd0, bus[0].wb_stb_o}, 32'd0);
    check("t6_dat", bus[0].wb_dat_o, 32'd0);
    check("t6_adr", bus[0].wb_adr_o, 32'd0);
    check("t6_cpu", {31'd0, a_cpu}, 32'd1);
    check("t6_wc",  {2'd0, a_wc}, 32'd0);
    g_slv[0].stall = 0;
    g_slv[1].stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    foreach (img3[i]) send8(img3[i]);
    h8_done = 1'b1;
    wait_ld_a();
    check("t6_ld",   {31'd0, a_ld}, 32'd1);
    check("t6_nw",   g_slv[0].nw, 32'd1);
    check("t6_adr0", g_slv[0].adr_log[0], 32'h100);
    check("t6_dat0", g_slv[0].dat_log[0], 32'hDEADBEEF);
    check("t6_sum",  a_sum, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
